// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C target: FSM state encoding, ACK/NACK
// bus levels and default configuration values.
package i2c_slave_pkg;

  localparam logic [6:0] SLAVE_ADDR_DEFAULT = 7'h25;
  localparam int         FILTER_LEN_DEFAULT = 3;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    RX_DATA   = 4'd3,
    RX_ACK    = 4'd4,
    TX_LOAD   = 4'd5,
    TX_DATA   = 4'd6,
    TX_ACK    = 4'd7,
    WAIT_STOP = 4'd8
  } state_t;

endpackage

// File: rtl/i2c_slave_filter.sv
// Conditions one asynchronous bus line: 2-flop synchronizer, stable-count glitch
// filter, and one-cycle rise/fall pulses on the filtered level.
module i2c_slave_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          sync1, sync2, filt_q, filt_d;
  logic [CW-1:0] cnt;

  // Reset to 1 so an idle (pulled-up) bus produces no spurious edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      filt_q <= 1'b1;
      filt_d <= 1'b1;
      cnt    <= '0;
    end else begin
      sync1  <= pin;
      sync2  <= sync1;
      filt_d <= filt_q;
      if (sync2 == filt_q) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        filt_q <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign level = filt_q;
  assign rise  = filt_q & ~filt_d;
  assign fall  = ~filt_q & filt_d;

endmodule

// File: rtl/i2c_slave_target.sv
// I2C target: START/STOP detection, fixed 7-bit address match, byte receive and
// transmit. Optional clock stretching is enabled by I2C_SLAVE_CLK_STRETCH_EN.
module i2c_slave_target import i2c_slave_pkg::*; #(
  parameter logic [6:0] SLAVE_ADDR = SLAVE_ADDR_DEFAULT,
  parameter int         FILTER_LEN = FILTER_LEN_DEFAULT
) (
  input  logic       i2c_core_clk_i,
  input  logic       i2c_core_rst_ni,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic       scl_oe_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       busy_o,
  output logic [3:0] state_o
);

`ifdef I2C_SLAVE_CLK_STRETCH_EN
  localparam bit STRETCH_EN = 1'b1;
`else
  localparam bit STRETCH_EN = 1'b0;
`endif

  logic scl, scl_rise, scl_fall, sda, sda_rise, sda_fall;

  i2c_slave_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk(i2c_core_clk_i), .rst_n(i2c_core_rst_ni), .pin(scl_i),
    .level(scl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_slave_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk(i2c_core_clk_i), .rst_n(i2c_core_rst_ni), .pin(sda_i),
    .level(sda), .rise(sda_rise), .fall(sda_fall)
  );

  state_t     state;
  logic [7:0] shift;
  logic [2:0] bit_cnt;
  logic       byte_done, rw, rx_nack;
  logic       start_cond, stop_cond, tx_load_go;

  assign start_cond = sda_fall & scl;
  assign stop_cond  = sda_rise & scl;

  // A transmit byte is fetched on the scl_fall that ends an ACK slot, or
  // every cycle while parked in TX_LOAD waiting for data.
  assign tx_load_go = (scl_fall & ((state == ADDR_ACK & rw) | state == TX_ACK))
                    | (state == TX_LOAD);

  // User handshakes: rx_valid_o and tx_ready_o are single-cycle strobes; the
  // user must hold rx_ready_i / tx_valid_i steady at the byte boundary where
  // they are sampled, and tx_data_i is captured in the cycle tx_ready_o rises.
  always_ff @(posedge i2c_core_clk_i or negedge i2c_core_rst_ni) begin
    if (!i2c_core_rst_ni) begin
      state      <= IDLE;
      shift      <= 8'h00;
      bit_cnt    <= 3'd0;
      byte_done  <= 1'b0;
      rw         <= 1'b0;
      rx_nack    <= 1'b0;
      sda_oe_o   <= 1'b0;
      scl_oe_o   <= 1'b0;
      rx_data_o  <= 8'h00;
      rx_valid_o <= 1'b0;
      tx_ready_o <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      rx_valid_o <= 1'b0;
      tx_ready_o <= 1'b0;
      if (start_cond || stop_cond) begin
        state     <= start_cond ? ADDR : IDLE;
        bit_cnt   <= 3'd0;
        byte_done <= 1'b0;
        sda_oe_o  <= 1'b0;
        scl_oe_o  <= 1'b0;
        busy_o    <= 1'b0;
      end else if (tx_load_go) begin
        if (tx_valid_i) begin
          shift      <= tx_data_i;
          tx_ready_o <= 1'b1;
          sda_oe_o   <= ~tx_data_i[7];
          scl_oe_o   <= 1'b0;
          state      <= TX_DATA;
        end else if (STRETCH_EN) begin
          sda_oe_o <= 1'b0;
          scl_oe_o <= 1'b1;
          state    <= TX_LOAD;
        end else begin
          shift    <= 8'hFF;
          sda_oe_o <= 1'b0;
          state    <= TX_DATA;
        end
      end else begin
        case (state)
          ADDR, RX_DATA: begin
            if (scl_rise) begin
              shift     <= {shift[6:0], sda};
              bit_cnt   <= bit_cnt + 3'd1;
              byte_done <= (bit_cnt == 3'd7);
            end else if (state == ADDR && scl_fall && byte_done) begin
              byte_done <= 1'b0;
              if (shift[7:1] == SLAVE_ADDR) begin
                rw       <= shift[0];
                busy_o   <= 1'b1;
                sda_oe_o <= 1'b1;
                state    <= ADDR_ACK;
              end else begin
                state <= IDLE;
              end
            end else if (state == RX_DATA && byte_done && (scl_fall || scl_oe_o)) begin
              if (rx_ready_i) begin
                byte_done  <= 1'b0;
                rx_data_o  <= shift;
                rx_valid_o <= 1'b1;
                rx_nack    <= 1'b0;
                sda_oe_o   <= 1'b1;
                scl_oe_o   <= 1'b0;
                state      <= RX_ACK;
              end else if (STRETCH_EN) begin
                scl_oe_o <= 1'b1;
              end else begin
                byte_done <= 1'b0;
                rx_nack   <= 1'b1;
                state     <= RX_ACK;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              sda_oe_o <= 1'b0;
              state    <= RX_DATA;
            end
          end
          RX_ACK: begin
            if (scl_fall) begin
              sda_oe_o <= 1'b0;
              state    <= rx_nack ? WAIT_STOP : RX_DATA;
            end
          end
          TX_DATA: begin
            if (scl_fall) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                sda_oe_o <= 1'b0;
                state    <= TX_ACK;
              end else begin
                shift    <= {shift[6:0], 1'b1};
                sda_oe_o <= ~shift[6];
              end
            end
          end
          TX_ACK: begin
            if (scl_rise && sda == I2C_NACK) state <= WAIT_STOP;
          end
          IDLE, TX_LOAD, WAIT_STOP: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_i2c_slave_target.sv
// Bench for i2c_slave_target: bit-level open-drain I2C master driver, rx strobe
// scoreboard, directed write/read/NACK/reset/repeated-START sequences.
`timescale 1ns/1ps
module tb_i2c_slave_target;

  localparam int Q = 6;  // quarter of an SCL period in core cycles
`ifdef I2C_SLAVE_CLK_STRETCH_EN
  localparam bit STRETCH = 1'b1;
`else
  localparam bit STRETCH = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       scl_m = 1'b1, sda_m = 1'b1;  // master drive, 1 = released
  logic       scl_line, sda_line;
  logic       sda_oe_o, scl_oe_o, rx_valid_o, tx_ready_o, busy_o;
  logic [7:0] rx_data_o;
  logic [7:0] tx_data_i = 8'h00;
  logic       tx_valid_i = 1'b0;
  logic       rx_ready_i = 1'b1;
  logic [3:0] state_o;

  assign scl_line = scl_m & ~scl_oe_o;
  assign sda_line = sda_m & ~sda_oe_o;

  i2c_slave_target dut (
    .i2c_core_clk_i(clk), .i2c_core_rst_ni(rst_n),
    .scl_i(scl_line), .sda_i(sda_line),
    .sda_oe_o(sda_oe_o), .scl_oe_o(scl_oe_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .busy_o(busy_o), .state_o(state_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard / user-side model ----------------
  logic [7:0] exp_q[$];
  logic [7:0] tx_src[$];
  int         rx_seen = 0;
  int         tx_seen = 0;

  always @(negedge clk) begin
    if (rx_valid_o) begin
      rx_seen++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rx_unexpected: got %02h expected no strobe", rx_data_o);
      end else begin
        check("rx_data", rx_data_o, exp_q.pop_front());
      end
    end
    if (tx_ready_o) begin
      tx_seen++;
      if (tx_src.size() > 0) void'(tx_src.pop_front());
    end
    tx_valid_i = (tx_src.size() > 0);
    tx_data_i  = tx_valid_i ? tx_src[0] : 8'h00;
  end

  // ---------------- master driver tasks ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scl_high();
    int k = 0;
    scl_m = 1'b1;
    while (!scl_line && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (!scl_line) begin
      n_checks++;
      n_fail++;
      $display("FAIL scl_release_timeout: got scl=0 expected 1 within 1000 cycles");
    end
  endtask

  task automatic put_bit(input logic b);
    wait_cyc(Q); sda_m = b; wait_cyc(Q);
    scl_high(); wait_cyc(2*Q); scl_m = 1'b0;
  endtask

  task automatic get_bit(output logic b);
    wait_cyc(Q); sda_m = 1'b1; wait_cyc(Q);
    scl_high(); wait_cyc(Q); b = sda_line; wait_cyc(Q); scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(ack);
  endtask

  task automatic do_start();
    wait_cyc(Q); sda_m = 1'b1; wait_cyc(Q);
    scl_high(); wait_cyc(2*Q); sda_m = 1'b0; wait_cyc(2*Q); scl_m = 1'b0;
  endtask

  task automatic do_stop();
    wait_cyc(Q); sda_m = 1'b0; wait_cyc(Q);
    scl_high(); wait_cyc(2*Q); sda_m = 1'b1; wait_cyc(4*Q);
  endtask

  // ---------------- directed sequences ----------------
  logic [7:0] wr_bytes [3] = '{8'h8A, 8'h2B, 8'hC3};
  logic [7:0] rd_exp   [4] = '{8'h94, 8'hC5, 8'h21, 8'h84};
  logic [7:0] d;
  logic       ack;
  int         t0;

  initial begin
    wait_cyc(5);
    rst_n = 1'b1;
    wait_cyc(3);
    check("rst_sda_oe", sda_oe_o, 0);
    check("rst_scl_oe", scl_oe_o, 0);
    check("rst_rx_data", rx_data_o, 8'h00);
    check("rst_rx_valid", rx_valid_o, 0);
    check("rst_tx_ready", tx_ready_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_state", state_o, 0);

    // write 0x25: 8A 2B C3
    do_start();
    send_byte(8'h4A, ack); check("wr_addr_ack", ack, 0);
    check("wr_busy", busy_o, 1);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(wr_bytes[i]);
      send_byte(wr_bytes[i], ack);
      check("wr_data_ack", ack, 0);
    end
    do_stop();
    check("wr_busy_after_stop", busy_o, 0);
    check("wr_state_after_stop", state_o, 0);

    // wrong address 0x34
    do_start();
    send_byte(8'h68, ack); check("bad_addr_nack", ack, 1);
    check("bad_addr_busy", busy_o, 0);
    check("bad_addr_state", state_o, 0);
    do_stop();

    // read 0x25: 94 C5 21 84, NACK the last
    for (int i = 0; i < 4; i++) tx_src.push_back(rd_exp[i]);
    t0 = tx_seen;
    do_start();
    send_byte(8'h4B, ack); check("rd_addr_ack", ack, 0);
    check("rd_busy", busy_o, 1);
    for (int i = 0; i < 4; i++) begin
      recv_byte(d, (i == 3));
      check("rd_data", d, rd_exp[i]);
    end
    wait_cyc(10);
    check("rd_wait_stop", state_o, 8);
    check("rd_tx_ready_count", tx_seen - t0, 4);
    do_stop();
    check("rd_state_after_stop", state_o, 0);
    check("rd_busy_after_stop", busy_o, 0);

    // write with rx_ready_i low on byte 2
    do_start();
    send_byte(8'h4A, ack); check("nr_addr_ack", ack, 0);
    exp_q.push_back(8'h11);
    send_byte(8'h11, ack); check("nr_byte1_ack", ack, 0);
    rx_ready_i = 1'b0;
    if (STRETCH) exp_q.push_back(8'h22);
    fork
      begin
        wait_cyc(300);
        check("nr_scl_hold", scl_oe_o, STRETCH);
        rx_ready_i = 1'b1;
      end
    join_none
    send_byte(8'h22, ack);
    check("nr_byte2_ack", ack, STRETCH ? 0 : 1);
    wait_cyc(150);
    check("nr_state", state_o, STRETCH ? 3 : 8);
    do_stop();
    check("nr_busy_after_stop", busy_o, 0);

    // asynchronous reset during bit 4 of a read
    tx_src.push_back(8'h00);
    do_start();
    send_byte(8'h4B, ack); check("rst_rd_addr_ack", ack, 0);
    for (int i = 0; i < 3; i++) begin
      get_bit(ack);
      check("rst_rd_bit", ack, 0);
    end
    wait_cyc(Q + 3);
    check("rst_pre_drive", sda_oe_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_sda", sda_oe_o, 0);
    check("rst_async_busy", busy_o, 0);
    check("rst_async_state", state_o, 0);
    scl_m = 1'b1;
    sda_m = 1'b1;
    wait_cyc(4);
    rst_n = 1'b1;
    wait_cyc(20);
    do_start();
    send_byte(8'h4A, ack); check("post_rst_addr_ack", ack, 0);
    check("post_rst_busy", busy_o, 1);
    do_stop();

    // repeated START after the write address ACK, then a read
    tx_src.push_back(8'h3C);
    do_start();
    send_byte(8'h4A, ack); check("rs_wr_addr_ack", ack, 0);
    do_start();
    check("rs_state_addr", state_o, 1);
    check("rs_busy_cleared", busy_o, 0);
    send_byte(8'h4B, ack); check("rs_rd_addr_ack", ack, 0);
    recv_byte(d, 1'b1);
    check("rs_rd_data", d, 8'h3C);
    wait_cyc(10);
    check("rs_wait_stop", state_o, 8);
    do_stop();
    check("rs_state_after_stop", state_o, 0);

    // ---------------- final report ----------------
    wait_cyc(10);
    check("rx_leftover", exp_q.size(), 0);
    check("rx_strobe_total", rx_seen, STRETCH ? 5 : 4);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion expected finish before 5 ms");
    $fatal(1);
  end

endmodule

// File: doc/i2c_slave_target.md
# i2c_slave_target

I2C target (slave) block that responds to the I2C master core on the shared SDA/SCL bus. Detects START/STOP, matches a fixed 7-bit address, and ACKs. Receives write bytes into a user-side strobe interface and shifts out read bytes taken from a user-side valid/ready interface. Sits on the board-level bus as the peer of the APB-driven master, and is reused as the in-system responder for loopback and bring-up.

## Interface
- SLAVE_ADDR, 7'h25, 7-bit address the block answers to (0100_101).
- FILTER_LEN, 3, glitch-filter depth in core cycles for SCL and SDA.
- i2c_core_clk_i  in  1  core clock; the only clock.
- i2c_core_rst_ni  in  1  asynchronous, active-low reset.
- scl_i  in  1  bus SCL level (asynchronous).
- sda_i  in  1  bus SDA level (asynchronous).
- sda_oe_o  out  1  1 = pull SDA low. The wrapper maps this to sda = sda_oe_o ? 0 : z.
- scl_oe_o  out  1  1 = pull SCL low (clock stretch). Held 0 when stretching is compiled out.
- rx_data_o  out  8  last received data byte.
- rx_valid_o  out  1  one-cycle strobe: rx_data_o is new.
- rx_ready_i  in  1  user can accept a byte; sampled when a byte completes.
- tx_data_i  in  8  next byte to return on a read.
- tx_valid_i  in  1  tx_data_i is valid.
- tx_ready_o  out  1  one-cycle strobe: tx_data_i latched this cycle.
- busy_o  out  1  1 from an address match until STOP or a repeated START.

## Operation
- **Input conditioning**
  - scl_i and sda_i pass through a 2-flop synchronizer, then a FILTER_LEN majority/stable filter.
  - Edges (scl_rise, scl_fall) are one-cycle pulses on the filtered signals.
- **Bus conditions**
  - START: filtered SDA falls while filtered SCL is high.
  - STOP: filtered SDA rises while filtered SCL is high.
  - Both are detected in every state. START always goes to ADDR. STOP always goes to IDLE, releases SDA and SCL, and clears busy_o.
- **States**
  - IDLE: wait for START.
  - ADDR: shift 8 bits on scl_rise, MSB first.
    - Bits[7:1] == SLAVE_ADDR: go to ADDR_ACK and set busy_o.
    - Otherwise: go to IDLE with nothing driven.
  - ADDR_ACK: drive SDA low from the scl_fall after bit 8 until the next scl_fall. Then go to RX_DATA if R/W=0, or TX_LOAD if R/W=1.
  - RX_DATA: shift 8 bits on scl_rise. On the scl_fall after bit 8:
    - rx_ready_i=1: update rx_data_o, pulse rx_valid_o, enter RX_ACK driving SDA low.
    - rx_ready_i=0: enter RX_ACK with SDA released (NACK), no strobe.
  - RX_ACK: release SDA on the next scl_fall, then go to RX_DATA. After a NACK, go to WAIT_STOP instead.
  - TX_LOAD: in the same cycle as the ACK-ending scl_fall:
    - tx_valid_i=1: latch tx_data_i into the shift register, pulse tx_ready_o.
    - tx_valid_i=0: load 8'hFF.
  - TX_DATA:
    - Drive SDA from the MSB; shift on each scl_fall.
    - A 1 bit means SDA is released; a 0 bit means SDA is pulled low.
    - After 8 bits, release SDA and go to TX_ACK.
  - TX_ACK: sample master ACK on scl_rise. 0: go to TX_LOAD at the next scl_fall. 1 (NACK): go to WAIT_STOP.
  - WAIT_STOP: drive nothing; leave only on STOP or START.
- Bit counter is 3 bits, wraps 7→0 at each byte boundary, and clears on START.

## Timing
- Reset values: sda_oe_o=0, scl_oe_o=0, rx_data_o=8'h00, rx_valid_o=0, tx_ready_o=0, busy_o=0, state=IDLE.
- Reset asserted mid-transfer releases the bus immediately and asynchronously.
- Input latency: a bus edge reaches the FSM 2+FILTER_LEN cycles after the pin change.
- Minimum SCL high or low time: FILTER_LEN+3 core cycles. With the defaults this is 6 cycles.
- SDA changes only in the cycle after scl_fall is detected, so setup time equals the SCL low time minus that latency.
- rx_valid_o and tx_ready_o are exactly one cycle wide, and at most one fires per byte.
- START and scl_fall in the same cycle: START wins.

## Configuration
- I2C_SLAVE_CLK_STRETCH_EN defined:
  - rx_ready_i=0 at the byte end: hold scl_oe_o=1 from that scl_fall until rx_ready_i rises, then strobe and ACK.
  - tx_valid_i=0 in TX_LOAD: hold scl_oe_o=1 until tx_valid_i=1.
  - scl_oe_o releases 1 cycle after the condition clears.
- Undefined: scl_oe_o is tied 0. Behaviour is the NACK / 8'hFF rules above.

## Structure
- Package i2c_slave_pkg holds:
  - the state enum (IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_LOAD, TX_DATA, TX_ACK, WAIT_STOP);
  - constants I2C_ACK=1'b0 and I2C_NACK=1'b1;
  - the default address constant.
- Sub-module i2c_slave_filter: synchronizer, glitch filter, and rise/fall pulses. Instantiated once for SCL and once for SDA.

## Test plan
- Master writes to address 0x25 with bytes 0x8A, 0x2B, 0xC3, then STOP. Expect:
  - SDA low in the ACK slot after the address and after each byte;
  - rx_valid_o pulses with 0x8A, 0x2B, 0xC3;
  - busy_o falls at STOP.
- Master addresses 0x34 (write). Expect no ACK (SDA high in slot 9), no strobes, busy_o stays 0.
- Master reads 0x25 with tx bytes 0x94, 0xC5, 0x21, 0x84 supplied, ACKing the first three and NACKing the last. Expect:
  - the bus carries exactly those bytes;
  - four tx_ready_o pulses;
  - WAIT_STOP, then IDLE after STOP.
- Write to 0x25 with rx_ready_i=0 on byte 2. Expect NACK in slot 9 and only one strobe. With the macro defined, expect SCL held low until rx_ready_i=1, then ACK.
- Assert i2c_core_rst_ni during bit 4 of a read. Expect sda_oe_o=0 immediately; the next START + address 0x25 is ACKed normally.
- Repeated START after the write ACK, then a read. Expect ADDR re-entered, bit counter cleared, read data correct.
